// File: rtl/walker_enemy_if.sv
// Signal bundle between walker_enemy and the game-logic layer.
// slave = enemy controller side, master = driver/observer side.
interface walker_enemy_if;
  logic       frame_clk;
  logic       start;
  logic       kill;
  logic       Shift;
  logic [9:0] spawnX;
  logic [9:0] spawnY;
  logic       spawn_dir;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] Mario_X_Pos;
  logic [9:0] Mario_Y_Pos;
  logic       Mario_falling;
  logic [2:0] poll_left;
  logic [2:0] poll_right;
  logic [2:0] poll_down;
  logic       isAlive_out;
  logic       kill_Mario;
  logic       stomped;
  logic [9:0] X_Pos;
  logic [9:0] Y_Pos;
  logic       draw_is_enemy;
  logic [1:0] sprite_frame;

  modport slave (
    input  frame_clk, start, kill, Shift, spawnX, spawnY, spawn_dir,
           DrawX, DrawY, Mario_X_Pos, Mario_Y_Pos, Mario_falling,
           poll_left, poll_right, poll_down,
    output isAlive_out, kill_Mario, stomped, X_Pos, Y_Pos,
           draw_is_enemy, sprite_frame
  );

  modport master (
    output frame_clk, start, kill, Shift, spawnX, spawnY, spawn_dir,
           DrawX, DrawY, Mario_X_Pos, Mario_Y_Pos, Mario_falling,
           poll_left, poll_right, poll_down,
    input  isAlive_out, kill_Mario, stomped, X_Pos, Y_Pos,
           draw_is_enemy, sprite_frame
  );
endinterface

// File: rtl/walker_enemy.sv
// Ground-walking enemy: spawn, patrol with wall turns, stomp/side-hit, squish, despawn.
// Define ENEMY_GRAVITY_EN to build the FALL state and the poll_down gravity logic.
module walker_enemy #(
  parameter logic [9:0] X_SIZE        = 10'd20,
  parameter logic [9:0] Y_SIZE        = 10'd20,
  parameter logic [9:0] X_STEP        = 10'd1,
  parameter logic [9:0] GRAVITY       = 10'd1,
  parameter logic [9:0] MAX_FALL      = 10'd8,
  parameter logic [9:0] X_MIN         = 10'd120,
  parameter logic [9:0] X_MAX         = 10'd519,
  parameter logic [9:0] Y_FLOOR       = 10'd479,
  parameter logic [9:0] SHIFT_AMT     = 10'd40,
  parameter logic [9:0] MARIO_HALF    = 10'd20,
  parameter logic [5:0] SQUISH_FRAMES = 6'd30,
  parameter logic [3:0] ANIM_PERIOD   = 4'd15
) (
  input  logic           Clk,
  input  logic           Reset,
  walker_enemy_if.slave  bus
);

  localparam logic [9:0]  X_STEP_NEG = 10'(-X_STEP);
  localparam logic [10:0] X_REACH    = {1'b0, X_SIZE} + {1'b0, MARIO_HALF};
  localparam logic [10:0] Y_REACH    = {1'b0, Y_SIZE} + {1'b0, MARIO_HALF};

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_FALL, S_SQUISH} state_e;

  state_e     state_q, state_d;
  logic       fc_sync_q, fc_prev_q, tick_q;
  logic [9:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic       kill_mario_q, kill_mario_d, stomped_q, stomped_d;
  logic [1:0] sprite_q, sprite_d;
  logic [3:0] anim_q, anim_d, anim_n;
  logic [5:0] sq_q, sq_d, sq_n;
  logic [9:0] vx_n, shift_c;

  logic [10:0] mdx_c, mdy_c, mdx_abs_c, mdy_abs_c;
  logic [10:0] ddx_c, ddy_c, ddx_abs_c, ddy_abs_c;
  logic        overlap_c, stomp_c, leave_c, wall_c;
  logic        alive_c, draw_c;

  // Frame tick: synchronise frame_clk, then register its rising edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_sync_q <= 1'b0;
      fc_prev_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      fc_sync_q <= bus.frame_clk;
      fc_prev_q <= fc_sync_q;
      tick_q    <= fc_sync_q & ~fc_prev_q;
    end
  end

  // Mario contact test on 11-bit signed differences
  assign mdx_c     = {1'b0, bus.Mario_X_Pos} - {1'b0, x_q};
  assign mdy_c     = {1'b0, bus.Mario_Y_Pos} - {1'b0, y_q};
  assign mdx_abs_c = mdx_c[10] ? 11'(-mdx_c) : mdx_c;
  assign mdy_abs_c = mdy_c[10] ? 11'(-mdy_c) : mdy_c;
  assign overlap_c = (mdx_abs_c < X_REACH) && (mdy_abs_c < Y_REACH);
  assign stomp_c   = overlap_c && bus.Mario_falling && (bus.Mario_Y_Pos < y_q);

  assign wall_c  = 10'(x_q + X_SIZE) >= X_MAX;
  assign shift_c = bus.Shift ? SHIFT_AMT : 10'd0;

`ifdef ENEMY_GRAVITY_EN
  logic [9:0] vy_sum, vy_n;
  assign vy_sum  = 10'(vy_q + GRAVITY);
  assign vy_n    = (vy_sum > MAX_FALL) ? MAX_FALL : vy_sum;
  assign leave_c = (10'(x_q + X_SIZE) < X_MIN) || (10'(y_q - Y_SIZE) > Y_FLOOR);
`else
  logic unused_gravity;
  assign unused_gravity = ^{bus.poll_down, GRAVITY, MAX_FALL, Y_FLOOR};
  assign leave_c = 10'(x_q + X_SIZE) < X_MIN;
`endif

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      kill_mario_q <= 1'b0;
      stomped_q    <= 1'b0;
      sprite_q     <= 2'b00;
      anim_q       <= '0;
      sq_q         <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      kill_mario_q <= kill_mario_d;
      stomped_q    <= stomped_d;
      sprite_q     <= sprite_d;
      anim_q       <= anim_d;
      sq_q         <= sq_d;
    end
  end

  // Next state: kill > start > per-tick behaviour
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    kill_mario_d = kill_mario_q;
    stomped_d    = 1'b0;
    sprite_d     = sprite_q;
    anim_d       = anim_q;
    sq_d         = sq_q;
    vx_n         = vx_q;
    anim_n       = 4'(anim_q + 4'd1);
    sq_n         = 6'(sq_q + 6'd1);

    if (bus.kill) begin
      state_d      = S_IDLE;
      x_d          = '0;
      y_d          = '0;
      vx_d         = '0;
      vy_d         = '0;
      kill_mario_d = 1'b0;
      sprite_d     = 2'b00;
      anim_d       = '0;
      sq_d         = '0;
    end else if (bus.start) begin
      state_d      = S_WALK;
      x_d          = bus.spawnX;
      y_d          = 10'(bus.spawnY - Y_SIZE);
      vx_d         = bus.spawn_dir ? X_STEP : X_STEP_NEG;
      vy_d         = '0;
      kill_mario_d = 1'b0;
      sprite_d     = 2'b00;
      anim_d       = '0;
      sq_d         = '0;
    end else if (tick_q) begin
      case (state_q)
        S_WALK, S_FALL: begin
          if (stomp_c) begin
            state_d   = S_SQUISH;
            stomped_d = 1'b1;
            sprite_d  = 2'b10;
            vx_d      = '0;
            vy_d      = '0;
            sq_d      = '0;
          end else begin
            if (overlap_c) kill_mario_d = 1'b1;
            if (leave_c) begin
              state_d = S_IDLE;
            end else begin
              if (bus.poll_left != 3'd0)
                vx_n = X_STEP;
              else if ((bus.poll_right != 3'd0) || wall_c)
                vx_n = X_STEP_NEG;
              vx_d = vx_n;
              x_d  = 10'(x_q + vx_n - shift_c);
`ifdef ENEMY_GRAVITY_EN
              if (bus.poll_down == 3'd0) begin
                state_d = S_FALL;
                vy_d    = vy_n;
                y_d     = 10'(y_q + vy_n);
              end else begin
                state_d = S_WALK;
                vy_d    = '0;
              end
`endif
              if (anim_n == ANIM_PERIOD) begin
                anim_d   = '0;
                sprite_d = {sprite_q[1], ~sprite_q[0]};
              end else begin
                anim_d = anim_n;
              end
            end
          end
        end
        S_SQUISH: begin
          // Frozen in place, but still scrolls with the screen
          x_d  = 10'(x_q - shift_c);
          sq_d = sq_n;
          if (sq_n == SQUISH_FRAMES) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Sprite-box hit test against the current VGA pixel
  assign ddx_c     = {1'b0, bus.DrawX} - {1'b0, x_q};
  assign ddy_c     = {1'b0, bus.DrawY} - {1'b0, y_q};
  assign ddx_abs_c = ddx_c[10] ? 11'(-ddx_c) : ddx_c;
  assign ddy_abs_c = ddy_c[10] ? 11'(-ddy_c) : ddy_c;

  always_comb begin
    alive_c = (state_q == S_WALK) || (state_q == S_FALL);
    draw_c  = (state_q != S_IDLE) && (ddx_abs_c < {1'b0, X_SIZE})
              && (ddy_abs_c < {1'b0, Y_SIZE});
  end

  assign bus.isAlive_out   = alive_c;
  assign bus.draw_is_enemy = draw_c;
  assign bus.kill_Mario    = kill_mario_q;
  assign bus.stomped       = stomped_q;
  assign bus.X_Pos         = x_q;
  assign bus.Y_Pos         = y_q;
  assign bus.sprite_frame  = sprite_q;

endmodule

// File: tb/tb_walker_enemy.sv
// Directed bench for walker_enemy: stimulus pushes expected outputs into a queue,
// an independent monitor compares them shortly after each rising clock edge.
module tb_walker_enemy;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  walker_enemy_if bus();
  walker_enemy dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef enum logic [2:0] {F_X, F_Y, F_ALIVE, F_KILL, F_STOMP, F_SPRITE, F_DRAW} field_e;
  typedef struct packed {
    field_e     fld;
    logic [9:0] val;
    logic [7:0] tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] cur_tag  = 8'd0;

  function automatic logic [9:0] observe(field_e f);
    case (f)
      F_X:      return bus.X_Pos;
      F_Y:      return bus.Y_Pos;
      F_ALIVE:  return {9'd0, bus.isAlive_out};
      F_KILL:   return {9'd0, bus.kill_Mario};
      F_STOMP:  return {9'd0, bus.stomped};
      F_SPRITE: return {8'd0, bus.sprite_frame};
      default:  return {9'd0, bus.draw_is_enemy};
    endcase
  endfunction

  function automatic string fname(field_e f);
    case (f)
      F_X:      return "X_Pos";
      F_Y:      return "Y_Pos";
      F_ALIVE:  return "isAlive_out";
      F_KILL:   return "kill_Mario";
      F_STOMP:  return "stomped";
      F_SPRITE: return "sprite_frame";
      default:  return "draw_is_enemy";
    endcase
  endfunction

  task automatic expect_val(field_e f, logic [9:0] v);
    exp_t e;
    e.fld = f;
    e.val = v;
    e.tag = cur_tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every expectation queued before this edge is checked against settled outputs
  always @(posedge Clk) begin
    #2;
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (observe(mon_e.fld) === mon_e.val)
        n_pass++;
      else
        $display("FAIL step %0d %s: got %0d, expected %0d",
                 mon_e.tag, fname(mon_e.fld), observe(mon_e.fld), mon_e.val);
    end
  end

  // One frame tick; returns just after the clock edge that applies it
  task automatic tick();
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic spawn(logic [9:0] sx, logic [9:0] sy, logic dir);
    @(negedge Clk);
    bus.spawnX    = sx;
    bus.spawnY    = sy;
    bus.spawn_dir = dir;
    bus.start     = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_kill();
    @(negedge Clk);
    bus.kill = 1'b1;
    @(posedge Clk);
    #1;
    bus.kill = 1'b0;
  endtask

  task automatic mario(logic [9:0] mx, logic [9:0] my, logic falling);
    bus.Mario_X_Pos   = mx;
    bus.Mario_Y_Pos   = my;
    bus.Mario_falling = falling;
  endtask

  task automatic draw_at(logic [9:0] dx, logic [9:0] dy);
    bus.DrawX = dx;
    bus.DrawY = dy;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef ENEMY_GRAVITY_EN
  logic [9:0] fall_tbl [10];
  logic [9:0] gy, gvy;
  logic       galive;
`endif

  initial begin
    Reset = 1'b1;
    bus.frame_clk = 1'b0; bus.start = 1'b0; bus.kill = 1'b0; bus.Shift = 1'b0;
    bus.spawnX = '0; bus.spawnY = '0; bus.spawn_dir = 1'b0;
    bus.poll_left = 3'd0; bus.poll_right = 3'd0; bus.poll_down = 3'b001;
    draw_at(10'd0, 10'd0);
    mario(10'd0, 10'd0, 1'b0);

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    cur_tag = 8'd1;
    expect_val(F_X, 10'd0);      expect_val(F_Y, 10'd0);
    expect_val(F_ALIVE, 10'd0);  expect_val(F_KILL, 10'd0);
    expect_val(F_STOMP, 10'd0);  expect_val(F_SPRITE, 10'd0);
    expect_val(F_DRAW, 10'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Spawn walking left
    cur_tag = 8'd2;
    draw_at(10'd300, 10'd380);
    spawn(10'd300, 10'd400, 1'b0);
    expect_val(F_X, 10'd300);    expect_val(F_Y, 10'd380);
    expect_val(F_ALIVE, 10'd1);  expect_val(F_KILL, 10'd0);
    expect_val(F_SPRITE, 10'd0); expect_val(F_DRAW, 10'd1);

    cur_tag = 8'd3;
    ticks(10);
    expect_val(F_X, 10'd290);    expect_val(F_Y, 10'd380);
    expect_val(F_ALIVE, 10'd1);  expect_val(F_SPRITE, 10'd0);

    // Walk animation toggles on the 15th tick
    cur_tag = 8'd4;
    ticks(5);
    expect_val(F_X, 10'd285);    expect_val(F_SPRITE, 10'd1);

    // Left wall contact reverses to +1
    cur_tag = 8'd5;
    bus.poll_left = 3'b001;
    tick();
    bus.poll_left = 3'd0;
    expect_val(F_X, 10'd286);
    cur_tag = 8'd6;
    tick();
    expect_val(F_X, 10'd287);

    // Right bound: X+X_SIZE reaching 519 reverses to -1
    cur_tag = 8'd7;
    spawn(10'd497, 10'd400, 1'b1);
    ticks(2);
    expect_val(F_X, 10'd499);
    tick();
    expect_val(F_X, 10'd498);
    tick();
    expect_val(F_X, 10'd497);

    // Scroll while walking left: -1 step and -40 shift
    cur_tag = 8'd8;
    bus.Shift = 1'b1;
    tick();
    bus.Shift = 1'b0;
    expect_val(F_X, 10'd456);
    tick();
    expect_val(F_X, 10'd455);

    // Stomp from above
    cur_tag = 8'd9;
    spawn(10'd300, 10'd400, 1'b0);
    draw_at(10'd300, 10'd380);
    mario(10'd300, 10'd345, 1'b1);
    tick();
    mario(10'd0, 10'd0, 1'b0);
    expect_val(F_STOMP, 10'd1);  expect_val(F_SPRITE, 10'd2);
    expect_val(F_KILL, 10'd0);   expect_val(F_ALIVE, 10'd0);
    expect_val(F_X, 10'd300);    expect_val(F_Y, 10'd380);
    expect_val(F_DRAW, 10'd1);
    @(negedge Clk);
    expect_val(F_STOMP, 10'd0);

    cur_tag = 8'd10;
    bus.Shift = 1'b1;
    tick();
    bus.Shift = 1'b0;
    expect_val(F_X, 10'd260);
    draw_at(10'd260, 10'd380);
    ticks(28);
    expect_val(F_ALIVE, 10'd0);  expect_val(F_SPRITE, 10'd2);
    expect_val(F_DRAW, 10'd1);   expect_val(F_X, 10'd260);
    tick();
    expect_val(F_DRAW, 10'd0);   expect_val(F_ALIVE, 10'd0);

    // Side hit: kill_Mario sticks while the enemy keeps walking
    cur_tag = 8'd11;
    spawn(10'd300, 10'd400, 1'b0);
    mario(10'd262, 10'd380, 1'b0);
    tick();
    mario(10'd0, 10'd0, 1'b0);
    expect_val(F_KILL, 10'd1);   expect_val(F_X, 10'd299);
    expect_val(F_ALIVE, 10'd1);  expect_val(F_STOMP, 10'd0);
    tick();
    expect_val(F_KILL, 10'd1);   expect_val(F_X, 10'd298);
    spawn(10'd300, 10'd400, 1'b0);
    expect_val(F_KILL, 10'd0);

    // Despawn past the left playfield edge
    cur_tag = 8'd12;
    spawn(10'd101, 10'd400, 1'b0);
    ticks(2);
    expect_val(F_X, 10'd99);     expect_val(F_ALIVE, 10'd1);
    tick();
    expect_val(F_ALIVE, 10'd0);  expect_val(F_X, 10'd99);
    expect_val(F_DRAW, 10'd0);

    // Start during SQUISH respawns immediately
    cur_tag = 8'd13;
    spawn(10'd300, 10'd400, 1'b0);
    mario(10'd300, 10'd345, 1'b1);
    tick();
    mario(10'd0, 10'd0, 1'b0);
    expect_val(F_ALIVE, 10'd0);
    tick();
    spawn(10'd300, 10'd400, 1'b0);
    expect_val(F_ALIVE, 10'd1);  expect_val(F_SPRITE, 10'd0);
    expect_val(F_X, 10'd300);

    // Kill clears everything, including a sticky kill_Mario
    cur_tag = 8'd14;
    mario(10'd262, 10'd380, 1'b0);
    tick();
    mario(10'd0, 10'd0, 1'b0);
    expect_val(F_KILL, 10'd1);
    pulse_kill();
    expect_val(F_X, 10'd0);      expect_val(F_Y, 10'd0);
    expect_val(F_ALIVE, 10'd0);  expect_val(F_KILL, 10'd0);
    expect_val(F_SPRITE, 10'd0);

`ifdef ENEMY_GRAVITY_EN
    // Falling from Y=100: velocity 1..8 then capped
    cur_tag = 8'd15;
    fall_tbl = '{10'd101, 10'd103, 10'd106, 10'd110, 10'd115,
                 10'd121, 10'd128, 10'd136, 10'd144, 10'd152};
    spawn(10'd300, 10'd120, 1'b0);
    expect_val(F_Y, 10'd100);
    bus.poll_down = 3'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_val(F_Y, fall_tbl[i]);
    end
    cur_tag = 8'd16;
    bus.poll_down = 3'b010;
    tick();
    expect_val(F_Y, 10'd152);    expect_val(F_ALIVE, 10'd1);
    bus.poll_down = 3'd0;
    gy = 10'd152; gvy = 10'd0; galive = 1'b1;
    cur_tag = 8'd17;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (galive) begin
        if (10'(gy - 10'd20) > 10'd479) begin
          galive = 1'b0;
        end else begin
          gvy = (gvy >= 10'd8) ? 10'd8 : 10'(gvy + 10'd1);
          gy  = 10'(gy + gvy);
        end
      end
      expect_val(F_Y, gy);
      expect_val(F_ALIVE, {9'd0, galive});
    end
    expect_val(F_ALIVE, 10'd0);
    bus.poll_down = 3'b001;
`endif

    // Drain the scoreboard
    repeat (3) @(posedge Clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
